// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and operand-select stage feeding the ALU.
// Captures the decoded instruction with stall/flush control, registers the
// decoded ALU control code, and applies EX/MEM and MEM/WB forwarding
// combinationally on the registered source operands.
module id_ex_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            flush,
   input  logic            id_valid,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic [4:0]      id_rd,
   input  logic [2:0]      id_funct3,
   input  logic            id_funct7b5,
   input  logic            id_alu_src,
   input  logic [1:0]      id_alu_op,
   input  logic            id_reg_write,
   input  logic            exmem_reg_write,
   input  logic            memwb_reg_write,
   input  logic [4:0]      exmem_rd,
   input  logic [4:0]      memwb_rd,
   input  logic [XLEN-1:0] exmem_result,
   input  logic [XLEN-1:0] memwb_result,
   output logic [XLEN-1:0] in1,
   output logic [XLEN-1:0] in2,
   output logic [3:0]      alu_control,
   output logic [XLEN-1:0] ex_store_data,
   output logic [4:0]      ex_rd,
   output logic            ex_reg_write,
   output logic            ex_valid,
   output logic [1:0]      fwd_a,
   output logic [1:0]      fwd_b
);

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SUB = 4'b1000;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   // Decode the ALU control code from alu_op and the funct fields.
   // Immediate forms never subtract: bit 30 of an I-type is immediate data.
   function automatic logic [3:0] alu_decode(input logic [1:0] alu_op,
                                             input logic [2:0] funct3,
                                             input logic       funct7b5,
                                             input logic       alu_src);
      logic [3:0] ctl;
      ctl = ALU_ADD;
      case (alu_op)
         2'b01: ctl = ALU_SUB;
         2'b10: begin
            case (funct3)
               3'b000:  ctl = (funct7b5 && !alu_src) ? ALU_SUB : ALU_ADD;
               3'b100:  ctl = ALU_XOR;
               3'b110:  ctl = ALU_OR;
               3'b111:  ctl = ALU_AND;
               default: ctl = ALU_ADD;
            endcase
         end
         default: ctl = ALU_ADD;
      endcase
      return ctl;
   endfunction

   // Forward-select for one source index; EX/MEM has priority, x0 never forwards.
   function automatic logic [1:0] fwd_select(input logic [4:0] rs,
                                             input logic       em_we,
                                             input logic [4:0] em_rd,
                                             input logic       mw_we,
                                             input logic [4:0] mw_rd);
      logic [1:0] sel;
      sel = FWD_REG;
      if (em_we && (em_rd != 5'd0) && (em_rd == rs))
         sel = FWD_EXMEM;
      else if (mw_we && (mw_rd != 5'd0) && (mw_rd == rs))
         sel = FWD_MEMWB;
      return sel;
   endfunction

   logic            vld_p1;
   logic [4:0]      rs1_p1;
   logic [4:0]      rs2_p1;
   logic [4:0]      rd_p1;
   logic [XLEN-1:0] rs1_data_p1;
   logic [XLEN-1:0] rs2_data_p1;
   logic [XLEN-1:0] imm_p1;
   logic            alu_src_p1;
   logic            reg_write_p1;
   logic [3:0]      alu_ctl_p1;

   logic [XLEN-1:0] opa;
   logic [XLEN-1:0] opb;

   // ID -> EX boundary: reset/flush/bubble clear, stall holds, otherwise capture.
   always_ff @(posedge clk) begin
      if (reset || flush || (!stall && !id_valid)) begin
         vld_p1       <= 1'b0;
         rs1_p1       <= '0;
         rs2_p1       <= '0;
         rd_p1        <= '0;
         rs1_data_p1  <= '0;
         rs2_data_p1  <= '0;
         imm_p1       <= '0;
         alu_src_p1   <= 1'b0;
         reg_write_p1 <= 1'b0;
         alu_ctl_p1   <= ALU_AND;
      end else if (!stall) begin
         vld_p1       <= 1'b1;
         rs1_p1       <= id_rs1;
         rs2_p1       <= id_rs2;
         rd_p1        <= id_rd;
         rs1_data_p1  <= id_rs1_data;
         rs2_data_p1  <= id_rs2_data;
         imm_p1       <= id_imm;
         alu_src_p1   <= id_alu_src;
         reg_write_p1 <= id_reg_write;
         alu_ctl_p1   <= alu_decode(id_alu_op, id_funct3, id_funct7b5, id_alu_src);
      end
   end

   // Combinational forwarding and operand selection from live downstream results.
   always_comb begin
      fwd_a = fwd_select(rs1_p1, exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd);
      fwd_b = fwd_select(rs2_p1, exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd);
      case (fwd_a)
         FWD_EXMEM: opa = exmem_result;
         FWD_MEMWB: opa = memwb_result;
         default:   opa = rs1_data_p1;
      endcase
      case (fwd_b)
         FWD_EXMEM: opb = exmem_result;
         FWD_MEMWB: opb = memwb_result;
         default:   opb = rs2_data_p1;
      endcase
   end

   assign in1           = opa;
   assign in2           = alu_src_p1 ? imm_p1 : opb;
   assign ex_store_data = opb;
   assign alu_control   = alu_ctl_p1;
   assign ex_rd         = rd_p1;
   assign ex_reg_write  = reg_write_p1 & vld_p1;
   assign ex_valid      = vld_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver applies one stimulus per cycle
// and queues the expected EX-side view; a monitor compares after each edge.
module tb_id_ex_stage;

   typedef struct packed {
      logic        reset, stall, flush, id_valid;
      logic [31:0] rs1_data, rs2_data, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [2:0]  funct3;
      logic        b5, alu_src;
      logic [1:0]  alu_op;
      logic        reg_write;
      logic        em_we, mw_we;
      logic [4:0]  em_rd, mw_rd;
      logic [31:0] em_res, mw_res;
   } stim_t;

   typedef struct packed {
      logic [31:0] in1, in2, store;
      logic [3:0]  ctl;
      logic [4:0]  rd;
      logic        reg_write, valid;
      logic [1:0]  fwd_a, fwd_b;
   } exp_t;

   // Instruction held in the EX slot by the reference model.
   typedef struct packed {
      logic        valid;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] d1, d2, imm;
      logic        alu_src, reg_write;
      logic [3:0]  ctl;
   } slot_t;

   logic        clk = 1'b0;
   logic        reset, stall, flush, id_valid;
   logic [31:0] id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [2:0]  id_funct3;
   logic        id_funct7b5, id_alu_src, id_reg_write;
   logic [1:0]  id_alu_op;
   logic        exmem_reg_write, memwb_reg_write;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_result, memwb_result;
   logic [31:0] in1, in2, ex_store_data;
   logic [3:0]  alu_control;
   logic [4:0]  ex_rd;
   logic        ex_reg_write, ex_valid;
   logic [1:0]  fwd_a, fwd_b;

   int   n_total = 0;
   int   n_pass  = 0;
   exp_t expq[$];
   slot_t slot = '0;

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(32)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
      .id_funct7b5(id_funct7b5), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
      .id_reg_write(id_reg_write), .exmem_reg_write(exmem_reg_write),
      .memwb_reg_write(memwb_reg_write), .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
      .exmem_result(exmem_result), .memwb_result(memwb_result),
      .in1(in1), .in2(in2), .alu_control(alu_control), .ex_store_data(ex_store_data),
      .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_valid(ex_valid),
      .fwd_a(fwd_a), .fwd_b(fwd_b)
   );

   // Mnemonic-level ALU operation chosen by the instruction.
   function automatic logic [3:0] ref_ctl(stim_t s);
      if (s.alu_op == 2'b01) return 4'b1000;
      if (s.alu_op != 2'b10) return 4'b0010;
      if (s.funct3 == 3'b111) return 4'b0000;
      if (s.funct3 == 3'b110) return 4'b0001;
      if (s.funct3 == 3'b100) return 4'b0100;
      if (s.funct3 == 3'b000 && s.b5 && !s.alu_src) return 4'b1000;
      return 4'b0010;
   endfunction

   // Youngest matching writer supplies the value; x0 is never written.
   function automatic logic [33:0] ref_fwd(logic [4:0] rs, logic [31:0] regval, stim_t s);
      if (rs != 0 && s.em_we && s.em_rd == rs) return {2'b10, s.em_res};
      if (rs != 0 && s.mw_we && s.mw_rd == rs) return {2'b01, s.mw_res};
      return {2'b00, regval};
   endfunction

   task automatic chk(string name, logic [31:0] got, logic [31:0] want);
      n_total++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, want);
   endtask

   function automatic stim_t idle();
      stim_t s = '0;
      s.id_valid = 1'b1;
      return s;
   endfunction

   task automatic drive(stim_t s);
      logic [33:0] fa, fb;
      exp_t e;
      @(negedge clk);
      reset = s.reset; stall = s.stall; flush = s.flush; id_valid = s.id_valid;
      id_rs1_data = s.rs1_data; id_rs2_data = s.rs2_data; id_imm = s.imm;
      id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd; id_funct3 = s.funct3;
      id_funct7b5 = s.b5; id_alu_src = s.alu_src; id_alu_op = s.alu_op;
      id_reg_write = s.reg_write;
      exmem_reg_write = s.em_we; memwb_reg_write = s.mw_we;
      exmem_rd = s.em_rd; memwb_rd = s.mw_rd;
      exmem_result = s.em_res; memwb_result = s.mw_res;
      if (s.reset || s.flush || (!s.stall && !s.id_valid)) slot = '0;
      else if (!s.stall) slot = '{1'b1, s.rs1, s.rs2, s.rd, s.rs1_data, s.rs2_data,
                                  s.imm, s.alu_src, s.reg_write, ref_ctl(s)};
      fa = ref_fwd(slot.rs1, slot.d1, s);
      fb = ref_fwd(slot.rs2, slot.d2, s);
      e.in1 = fa[31:0];
      e.store = fb[31:0];
      e.in2 = slot.alu_src ? slot.imm : fb[31:0];
      e.ctl = slot.ctl;
      e.rd = slot.rd;
      e.reg_write = slot.valid && slot.reg_write;
      e.valid = slot.valid;
      e.fwd_a = fa[33:32];
      e.fwd_b = fb[33:32];
      expq.push_back(e);
   endtask

   // Monitor: after every edge, compare the DUT against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("in1", in1, e.in1);
            chk("in2", in2, e.in2);
            chk("store", ex_store_data, e.store);
            chk("alu_control", {28'd0, alu_control}, {28'd0, e.ctl});
            chk("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
            chk("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, e.reg_write});
            chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
            chk("fwd_a", {30'd0, fwd_a}, {30'd0, e.fwd_a});
            chk("fwd_b", {30'd0, fwd_b}, {30'd0, e.fwd_b});
         end
      end
   end

   initial begin
      stim_t s;
      logic [2:0] f3tab [4];
      f3tab[0] = 3'b111; f3tab[1] = 3'b110; f3tab[2] = 3'b100; f3tab[3] = 3'b000;

      // Reset with every input driven nonzero.
      s = '1;
      drive(s);

      // R-type operations, rs1 value 23, rs2 value 42, no forwarding.
      for (int i = 0; i < 5; i++) begin
         s = idle();
         s.rs1 = 5'd1; s.rs2 = 5'd2; s.rd = 5'd3; s.rs1_data = 32'd23; s.rs2_data = 32'd42;
         s.alu_op = 2'b10; s.reg_write = 1'b1;
         s.funct3 = (i < 4) ? f3tab[i] : 3'b000;
         s.b5 = (i == 3);
         drive(s);
      end

      // I-type with bit 30 set must still add.
      s = idle();
      s.rs1 = 5'd1; s.rs1_data = 32'd23; s.imm = 32'hFFFF_FFFF; s.alu_src = 1'b1;
      s.alu_op = 2'b10; s.funct3 = 3'b000; s.b5 = 1'b1; s.rd = 5'd4; s.reg_write = 1'b1;
      drive(s);

      // Forwarding: both stages target x5; EX/MEM wins, then MEM/WB, then none.
      s = idle();
      s.rs1 = 5'd5; s.rs2 = 5'd5; s.rs1_data = 32'd7; s.rs2_data = 32'd9; s.imm = 32'h55;
      s.rd = 5'd6; s.reg_write = 1'b1;
      s.em_we = 1'b1; s.em_rd = 5'd5; s.em_res = 32'd100;
      s.mw_we = 1'b1; s.mw_rd = 5'd5; s.mw_res = 32'd200;
      drive(s);
      s.stall = 1'b1; s.em_we = 1'b0;
      drive(s);
      s.em_we = 1'b1; s.em_rd = 5'd0; s.mw_rd = 5'd0;
      drive(s);
      s.stall = 1'b0; s.alu_src = 1'b1; s.em_rd = 5'd5; s.mw_rd = 5'd5;
      drive(s);

      // Three stall cycles with changing decode inputs, then release.
      for (int i = 0; i < 4; i++) begin
         s = idle();
         s.stall = (i < 3);
         s.rs1 = 5'($urandom_range(1, 31)); s.rs2 = 5'($urandom_range(1, 31));
         s.rd = 5'($urandom); s.rs1_data = $urandom; s.rs2_data = $urandom; s.imm = $urandom;
         s.funct3 = 3'($urandom); s.alu_op = 2'($urandom); s.b5 = 1'($urandom);
         s.reg_write = 1'b1;
         drive(s);
      end

      // Stall with flush gives a bubble; id_valid low alone gives a bubble too.
      s.stall = 1'b1; s.flush = 1'b1;
      drive(s);
      s.stall = 1'b0; s.flush = 1'b0;
      drive(s);
      s.id_valid = 1'b0;
      drive(s);

      // Randomised traffic with small register indices to provoke hazards.
      for (int i = 0; i < 300; i++) begin
         s.reset = ($urandom_range(0, 49) == 0);
         s.flush = ($urandom_range(0, 9) == 0);
         s.stall = ($urandom_range(0, 4) == 0);
         s.id_valid = ($urandom_range(0, 4) != 0);
         s.rs1_data = $urandom; s.rs2_data = $urandom; s.imm = $urandom;
         s.rs1 = 5'($urandom_range(0, 7)); s.rs2 = 5'($urandom_range(0, 7));
         s.rd = 5'($urandom); s.funct3 = 3'($urandom); s.b5 = 1'($urandom);
         s.alu_src = 1'($urandom); s.alu_op = 2'($urandom); s.reg_write = 1'($urandom);
         s.em_we = 1'($urandom); s.mw_we = 1'($urandom);
         s.em_rd = 5'($urandom_range(0, 7)); s.mw_rd = 5'($urandom_range(0, 7));
         s.em_res = $urandom; s.mw_res = $urandom;
         drive(s);
      end

      repeat (3) @(posedge clk);
      #2;
      if (expq.size() != 0) begin
         n_total++;
         $display("FAIL drain: %0d expectations left, expected 0", expq.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and operand-select stage of the RISC-V core, sitting directly upstream of the ALU. It captures decoded instruction fields from the decode stage every cycle, with stall and flush control. It registers the 4-bit ALU control code derived from ALU-op/funct fields. It then drives the ALU `in1`, `in2` and `alu_control` inputs, applying EX/MEM and MEM/WB result forwarding combinationally.

## Interface
- `XLEN`, 32, datapath width
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `stall`  in  1  hold all stage registers
- `flush`  in  1  load a bubble
- `id_valid`  in  1  decode slot holds a real instruction
- `id_rs1_data`, `id_rs2_data`  in  XLEN  register-file read data
- `id_imm`  in  XLEN  sign-extended immediate
- `id_rs1`, `id_rs2`, `id_rd`  in  5  register indices
- `id_funct3`  in  3  instruction funct3
- `id_funct7b5`  in  1  instruction bit 30
- `id_alu_src`  in  1  1 = in2 from immediate
- `id_alu_op`  in  2  00 add, 01 sub, 10 funct-decoded, 11 add
- `id_reg_write`  in  1  instruction writes rd
- `exmem_reg_write`, `memwb_reg_write`  in  1  downstream write enables
- `exmem_rd`, `memwb_rd`  in  5  downstream destinations
- `exmem_result`, `memwb_result`  in  XLEN  forwardable values
- `in1`, `in2`  out  XLEN  ALU operands
- `alu_control`  out  4  0000 AND, 0001 OR, 0010 ADD, 0100 XOR, 1000 SUB
- `ex_store_data`  out  XLEN  forwarded rs2 value
- `ex_rd`  out  5  registered rd
- `ex_reg_write`  out  1  registered write enable, gated by valid
- `ex_valid`  out  1  stage holds a real instruction
- `fwd_a`, `fwd_b`  out  2  forward select: 00 reg, 10 EX/MEM, 01 MEM/WB

## Operation
- Register priority per edge: `reset` > `flush` > `stall` > load.
- Reset and flush clear all stage registers to 0. Result: `ex_valid=0`, `ex_reg_write=0`, `ex_rd=0`, `alu_control=0000`, `in1=in2=ex_store_data=0`, `fwd_a=fwd_b=00`.
- Stall holds every register. Forwarding outputs still track the live `exmem_*`/`memwb_*` inputs.
- Load with `id_valid=0` is equivalent to a flush (bubble).
- `alu_control` is decoded at capture time and registered:
  - `alu_op` 00 or 11: ADD
  - `alu_op` 01: SUB
  - `alu_op` 10, by funct3:
    - 000: SUB if `funct7b5=1` and `alu_src=0`, else ADD
    - 100: XOR
    - 110: OR
    - 111: AND
    - any other funct3: ADD
- Forwarding for operand A, evaluated combinationally on registered rs1/rs1_data:
  - EX/MEM if `exmem_reg_write` and `exmem_rd!=0` and `exmem_rd==rs1`
  - else MEM/WB under the same rule using `memwb_*`
  - else registered register data
  - EX/MEM wins when both match.
- Operand B (`ex_store_data`) uses the same rule on rs2.
- `in1` = forwarded A.
- `in2` = registered imm if `alu_src=1`, else forwarded B.
- `x0` never forwards. Reads of `x0` pass the registered data, which the register file supplies as 0.

## Timing
- Latency: decode inputs appear on outputs 1 cycle after the capturing edge.
- Forwarding path is zero-latency, combinational from the `exmem_*`/`memwb_*` inputs.
- Reset is synchronous: outputs reach reset values after the first edge with `reset=1`. A reset mid-stall discards the held instruction.
- `flush` and `stall` both high: bubble is inserted.
- No internal hazard detection. Load-use stalls are the hazard unit's responsibility.

## Test plan
- Reset with all inputs nonzero -> after the edge, `ex_valid=0`, `alu_control=0000`, `in1=in2=0`, `ex_reg_write=0`.
- R-type, rs1=23, rs2=42, alu_op=10:
  - funct3=111 -> `alu_control=0000`, `in1=23`, `in2=42`
  - funct3=110 -> `0001`
  - funct3=100 -> `0100`
  - funct3=000 with b5=1 -> `1000`
  - funct3=000 with b5=0 -> `0010`
- I-type, alu_src=1, imm=0xFFFF_FFFF, funct3=000, b5=1 -> `alu_control=0010` (not SUB), `in2=0xFFFF_FFFF`.
- Forwarding, stage rs1=5 and rs2=5:
  - `exmem_rd=5`, result 100, and `memwb_rd=5`, result 200 -> `in1=100`, `fwd_a=10`
  - drop `exmem_reg_write` -> `in1=200`, `fwd_a=01`
  - rd=0 with all enables high -> `fwd_a=00`
  - alu_src=1 -> `ex_store_data=100`, `in2=imm`
- Stall held 3 cycles with changing ID inputs -> outputs constant. Release -> the new instruction appears 1 cycle later.
- `stall=1` and `flush=1` together -> bubble (`ex_valid=0`, `ex_reg_write=0`). With `id_valid=0` alone -> same bubble.
